// File: rtl/la_stable_timer.sv
// Multi-channel stable timer: per-channel TCFG/TVAL/TICLR, down-counter with
// one-shot or periodic reload, and a sticky TI pending bit per channel.
module la_stable_timer #(
  parameter int NUM_TIMERS = 1,
  parameter int TIMER_W    = 32,
  parameter int SEL_W      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csr_we,
  input  logic [SEL_W-1:0]      csr_sel,
  input  logic [1:0]            csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  input  logic                  timer_halt,
  output logic [NUM_TIMERS-1:0] ti_vec,
  output logic                  ti_irq
);

  localparam logic [1:0] ADDR_TCFG  = 2'd0;
  localparam logic [1:0] ADDR_TVAL  = 2'd1;
  localparam logic [1:0] ADDR_TICLR = 2'd2;

  logic [NUM_TIMERS-1:0][TIMER_W-1:0] r_tcfg;
  logic [NUM_TIMERS-1:0][TIMER_W-1:0] r_tval;
  logic [NUM_TIMERS-1:0]              r_ti;

  logic [NUM_TIMERS-1:0][TIMER_W-1:0] w_tcfg_nxt;
  logic [NUM_TIMERS-1:0][TIMER_W-1:0] w_tval_nxt;
  logic [NUM_TIMERS-1:0]              w_ti_nxt;

  // A TCFG write overrides counting for that cycle; a counting set beats a TICLR clear.
  always_comb begin
    for (int k = 0; k < NUM_TIMERS; k++) begin
      w_tcfg_nxt[k] = r_tcfg[k];
      w_tval_nxt[k] = r_tval[k];
      w_ti_nxt[k]   = r_ti[k];
      if (csr_we && (csr_sel == SEL_W'(k)) && (csr_addr == ADDR_TCFG)) begin
        w_tcfg_nxt[k] = csr_wdata[TIMER_W-1:0];
        w_tval_nxt[k] = {csr_wdata[TIMER_W-1:2], 2'b00};
      end else begin
        if (csr_we && (csr_sel == SEL_W'(k)) && (csr_addr == ADDR_TICLR) && csr_wdata[0]) begin
          w_ti_nxt[k] = 1'b0;
        end
        if (r_tcfg[k][0] && !timer_halt) begin
          if (r_tval[k] != '0) begin
            w_tval_nxt[k] = r_tval[k] - TIMER_W'(1);
            if (r_tval[k] == TIMER_W'(1)) begin
              w_ti_nxt[k] = 1'b1;
            end
          end else if (r_tcfg[k][1]) begin
            w_tval_nxt[k] = {r_tcfg[k][TIMER_W-1:2], 2'b00};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcfg <= '0;
      r_tval <= '0;
      r_ti   <= '0;
    end else begin
      r_tcfg <= w_tcfg_nxt;
      r_tval <= w_tval_nxt;
      r_ti   <= w_ti_nxt;
    end
  end

  // Out-of-range channel indices match no channel, so they read as zero.
  always_comb begin
    csr_rdata = '0;
    for (int k = 0; k < NUM_TIMERS; k++) begin
      if (csr_sel == SEL_W'(k)) begin
        case (csr_addr)
          ADDR_TCFG: csr_rdata = 32'(r_tcfg[k]);
          ADDR_TVAL: csr_rdata = 32'(r_tval[k]);
          default:   csr_rdata = '0;
        endcase
      end
    end
  end

  assign ti_vec = r_ti;
  assign ti_irq = |r_ti;

endmodule

// File: tb/tb_la_stable_timer.sv
// Directed bench for la_stable_timer: a single-channel 32-bit instance and a
// two-channel 16-bit instance, each with hand-computed expected values.
module tb_la_stable_timer;

  logic        clk;
  logic        rst_n;

  logic        aWe;
  logic        aSel;
  logic [1:0]  aAddr;
  logic [31:0] aWdata;
  logic [31:0] aRdata;
  logic        aHalt;
  logic        aTiVec;
  logic        aIrq;

  logic        bWe;
  logic        bSel;
  logic [1:0]  bAddr;
  logic [31:0] bWdata;
  logic [31:0] bRdata;
  logic        bHalt;
  logic [1:0]  bTiVec;
  logic        bIrq;

  int testsRun;
  int failures;
  logic [31:0] rd;

  la_stable_timer #(.NUM_TIMERS(1), .TIMER_W(32), .SEL_W(1)) dutA (
    .clk(clk), .rst_n(rst_n), .csr_we(aWe), .csr_sel(aSel), .csr_addr(aAddr),
    .csr_wdata(aWdata), .csr_rdata(aRdata), .timer_halt(aHalt),
    .ti_vec(aTiVec), .ti_irq(aIrq)
  );

  la_stable_timer #(.NUM_TIMERS(2), .TIMER_W(16), .SEL_W(1)) dutB (
    .clk(clk), .rst_n(rst_n), .csr_we(bWe), .csr_sel(bSel), .csr_addr(bAddr),
    .csr_wdata(bWdata), .csr_rdata(bRdata), .timer_halt(bHalt),
    .ti_vec(bTiVec), .ti_irq(bIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] addr, input logic [31:0] data);
    aWe = 1'b1; aSel = sel; aAddr = addr; aWdata = data;
    @(posedge clk);
    #1;
    aWe = 1'b0; aSel = 1'b0; aWdata = '0;
  endtask

  task automatic applyStimulusB(input logic sel, input logic [1:0] addr, input logic [31:0] data);
    bWe = 1'b1; bSel = sel; bAddr = addr; bWdata = data;
    @(posedge clk);
    #1;
    bWe = 1'b0; bSel = 1'b0; bWdata = '0;
  endtask

  task automatic readA(input logic sel, input logic [1:0] addr, output logic [31:0] d);
    aSel = sel; aAddr = addr;
    #1;
    d = aRdata;
    aSel = 1'b0;
  endtask

  task automatic readB(input logic sel, input logic [1:0] addr, output logic [31:0] d);
    bSel = sel; bAddr = addr;
    #1;
    d = bRdata;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun = 0; failures = 0;
    rst_n = 1'b0;
    aWe = 0; aSel = 0; aAddr = 0; aWdata = 0; aHalt = 0;
    bWe = 0; bSel = 0; bAddr = 0; bWdata = 0; bHalt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset, including an asynchronous assertion in the middle of a count
    readA(0, 2'd1, rd); checkOutput("rst_tval", rd, 32'h0);
    applyStimulus(0, 2'd0, 32'h41);
    step(2);
    readA(0, 2'd1, rd); checkOutput("pre_rst_tval", rd, 32'h3E);
    #1 rst_n = 1'b0;
    readA(0, 2'd0, rd); checkOutput("rst_lo_tcfg", rd, 32'h0);
    readA(0, 2'd1, rd); checkOutput("rst_lo_tval", rd, 32'h0);
    checkOutput("rst_lo_irq", {31'b0, aIrq}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);
    readA(0, 2'd0, rd); checkOutput("rst_rel_tcfg", rd, 32'h0);
    readA(0, 2'd1, rd); checkOutput("rst_rel_tval", rd, 32'h0);
    checkOutput("rst_rel_irq", {31'b0, aIrq}, 32'h0);
    readB(1, 2'd0, rd); checkOutput("rst_b_tcfg1", rd, 32'h0);

    // One-shot, R = 0x10
    applyStimulus(0, 2'd0, 32'h11);
    readA(0, 2'd1, rd); checkOutput("os_load", rd, 32'h10);
    readA(0, 2'd0, rd); checkOutput("os_tcfg", rd, 32'h11);
    step(1);
    readA(0, 2'd1, rd); checkOutput("os_dec", rd, 32'hF);
    step(14);
    readA(0, 2'd1, rd); checkOutput("os_tval1", rd, 32'h1);
    checkOutput("os_pre_irq", {31'b0, aIrq}, 32'h0);
    step(1);
    readA(0, 2'd1, rd); checkOutput("os_tval0", rd, 32'h0);
    checkOutput("os_irq", {31'b0, aIrq}, 32'h1);
    checkOutput("os_tivec", {31'b0, aTiVec}, 32'h1);
    applyStimulus(0, 2'd2, 32'h0);
    checkOutput("ticlr0_noeffect", {31'b0, aIrq}, 32'h1);
    step(100);
    readA(0, 2'd1, rd); checkOutput("os_hold", rd, 32'h0);
    applyStimulus(0, 2'd2, 32'h1);
    checkOutput("os_clear", {31'b0, aIrq}, 32'h0);
    step(100);
    checkOutput("os_no_reset", {31'b0, aIrq}, 32'h0);
    readA(0, 2'd2, rd); checkOutput("ticlr_read", rd, 32'h0);

    // Periodic, R = 8, period 9
    applyStimulus(0, 2'd0, 32'h0B);
    readA(0, 2'd1, rd); checkOutput("per_load", rd, 32'h8);
    step(8);
    readA(0, 2'd1, rd); checkOutput("per_zero1", rd, 32'h0);
    checkOutput("per_set1", {31'b0, aIrq}, 32'h1);
    applyStimulus(0, 2'd2, 32'h1);
    checkOutput("per_clr1", {31'b0, aIrq}, 32'h0);
    readA(0, 2'd1, rd); checkOutput("per_reload", rd, 32'h8);
    step(8);
    checkOutput("per_set2", {31'b0, aIrq}, 32'h1);
    applyStimulus(0, 2'd2, 32'h1);
    step(7);
    readA(0, 2'd1, rd); checkOutput("per_tval1", rd, 32'h1);
    checkOutput("per_clr2", {31'b0, aIrq}, 32'h0);
    applyStimulus(0, 2'd2, 32'h1);
    checkOutput("clr_vs_set", {31'b0, aIrq}, 32'h1);

    // Halt freezes counting but not CSR writes
    step(3);
    readA(0, 2'd1, rd); checkOutput("halt_pre", rd, 32'h6);
    aHalt = 1'b1;
    step(5);
    readA(0, 2'd1, rd); checkOutput("halt_frozen", rd, 32'h6);
    applyStimulus(0, 2'd2, 32'h1);
    checkOutput("halt_ticlr", {31'b0, aIrq}, 32'h0);
    readA(0, 2'd1, rd); checkOutput("halt_frozen2", rd, 32'h6);
    aHalt = 1'b0;
    step(1);
    readA(0, 2'd1, rd); checkOutput("halt_resume", rd, 32'h5);
    step(1);
    readA(0, 2'd1, rd); checkOutput("halt_resume2", rd, 32'h4);

    // Disabled load holds, TVAL writes and reserved/invalid accesses ignored
    applyStimulus(0, 2'd0, 32'h0A);
    readA(0, 2'd1, rd); checkOutput("dis_load", rd, 32'h8);
    step(5);
    readA(0, 2'd1, rd); checkOutput("dis_hold", rd, 32'h8);
    applyStimulus(0, 2'd1, 32'hFFFF_FFFF);
    readA(0, 2'd1, rd); checkOutput("tval_wr", rd, 32'h8);
    readA(0, 2'd0, rd); checkOutput("tval_wr_tcfg", rd, 32'h0A);
    applyStimulus(0, 2'd3, 32'h5);
    readA(0, 2'd3, rd); checkOutput("rsvd_read", rd, 32'h0);
    applyStimulus(1, 2'd0, 32'h11);
    readA(1, 2'd0, rd); checkOutput("badsel_read", rd, 32'h0);
    readA(0, 2'd0, rd); checkOutput("badsel_nochg", rd, 32'h0A);
    step(20);
    checkOutput("badsel_irq", {31'b0, aIrq}, 32'h0);

    // TCFG write on the edge where tval goes 1 -> 0
    applyStimulus(0, 2'd0, 32'h09);
    step(7);
    readA(0, 2'd1, rd); checkOutput("coll_pre", rd, 32'h1);
    applyStimulus(0, 2'd0, 32'h0D);
    readA(0, 2'd1, rd); checkOutput("coll_tval", rd, 32'hC);
    checkOutput("coll_noti", {31'b0, aIrq}, 32'h0);
    step(12);
    readA(0, 2'd1, rd); checkOutput("coll_later_tval", rd, 32'h0);
    checkOutput("coll_later_irq", {31'b0, aIrq}, 32'h1);

    // Two channels, 16-bit counters
    applyStimulusB(0, 2'd0, 32'hABCD_0005);
    applyStimulusB(1, 2'd0, 32'h0000_000D);
    readB(1, 2'd1, rd); checkOutput("b_ch1_load", rd, 32'hC);
    readB(0, 2'd0, rd); checkOutput("b_trunc", rd, 32'h5);
    readB(0, 2'd1, rd); checkOutput("b_ch0_tval", rd, 32'h3);
    checkOutput("b_vec0", {30'b0, bTiVec}, 32'h0);
    step(3);
    checkOutput("b_vec01", {30'b0, bTiVec}, 32'h1);
    checkOutput("b_irq", {31'b0, bIrq}, 32'h1);
    step(8);
    checkOutput("b_vec01_hold", {30'b0, bTiVec}, 32'h1);
    step(1);
    checkOutput("b_vec11", {30'b0, bTiVec}, 32'h3);
    applyStimulusB(1, 2'd2, 32'h1);
    checkOutput("b_clr_ch1", {30'b0, bTiVec}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
